// File: rtl/tiny_canvas_pkg.sv
// Shared types for the tiny canvas pixel path: coordinate/colour widths and the
// packed pixel entry used by the packet generator, pixel queue and I2C slave.
package tiny_canvas_pkg;
    localparam int COORD_W = 8;
    localparam int COLOR_W = 3;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } pixel_t;

    function automatic pixel_t make_pixel(input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y,
                                          input logic [COLOR_W-1:0] color);
        pixel_t p;
        p.x     = x;
        p.y     = y;
        p.color = color;
        return p;
    endfunction
endpackage

// File: rtl/pixel_queue_if.sv
// Handshake and status bundle between the pixel queue and its neighbours.
interface pixel_queue_if #(parameter int DEPTH = 8);
    import tiny_canvas_pkg::*;

    logic                  push;
    logic [COORD_W-1:0]    x_in;
    logic [COORD_W-1:0]    y_in;
    logic [COLOR_W-1:0]    color_in;
    logic                  pop;
    logic                  clear;
    logic [COORD_W-1:0]    head_x;
    logic [COORD_W-1:0]    head_y;
    logic [COLOR_W-1:0]    head_color;
    logic                  head_valid;
    logic [$clog2(DEPTH):0] level;
    logic                  almost_full;
    logic                  overflow;
    logic [7:0]            drop_count;

    modport master (
        output push, x_in, y_in, color_in, pop, clear,
        input  head_x, head_y, head_color, head_valid, level, almost_full,
               overflow, drop_count
    );

    modport slave (
        input  push, x_in, y_in, color_in, pop, clear,
        output head_x, head_y, head_color, head_valid, level, almost_full,
               overflow, drop_count
    );
endinterface

// File: rtl/pixel_queue_mem.sv
// Pixel entry storage: one synchronous write port, one combinational read port.
module pixel_queue_mem
    import tiny_canvas_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pixel_t        wdata,
    input  logic [AW-1:0] raddr,
    output pixel_t        rdata
);
    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pixel_queue.sv
// First-word-fall-through pixel queue with drop accounting and back-pressure hint.
module pixel_queue
    import tiny_canvas_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic clk,
    input  logic rst,
    pixel_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic [7:0]       drop_count;

    logic   empty;
    logic   full;
    logic   do_push;
    logic   do_pop;
    logic   drop;
    pixel_t wr_entry;
    pixel_t rd_entry;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = bus.pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign do_push = bus.push && (!full || do_pop);
    assign drop    = bus.push && full && !bus.pop;

    assign wr_entry = make_pixel(bus.x_in, bus.y_in, bus.color_in);

    pixel_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (do_push && !bus.clear),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (bus.clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (!do_push && do_pop)
                level <= level - 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF)
                    drop_count <= drop_count + 1'b1;
            end
        end
    end

    // Head reads zero whenever empty so uninitialised storage never leaks out.
    assign bus.head_valid  = !empty;
    assign bus.head_x      = empty ? '0 : rd_entry.x;
    assign bus.head_y      = empty ? '0 : rd_entry.y;
    assign bus.head_color  = empty ? '0 : rd_entry.color;
    assign bus.level       = level;
    assign bus.almost_full = (level >= LVL_W'(AFULL_LEVEL));
    assign bus.overflow    = overflow;
    assign bus.drop_count  = drop_count;
endmodule

// File: tb/tb_pixel_queue.sv
// Directed self-checking bench for pixel_queue.
module tb_pixel_queue;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pixel_queue_if #(.DEPTH(8)) bus ();

    pixel_queue #(.DEPTH(8), .AFULL_LEVEL(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic p, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] c, input logic q, input logic cl);
        bus.push     = p;
        bus.x_in     = x;
        bus.y_in     = y;
        bus.color_in = c;
        bus.pop      = q;
        bus.clear    = cl;
        @(posedge clk);
        #1;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
        checks++; if (bus.head_valid !== 1'b0) begin errors++; $display("FAIL reset_head_valid: got %0b expected 0", bus.head_valid); end
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %0b expected 0", bus.almost_full); end
        checks++; if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin errors++; $display("FAIL reset_flags: got ovf=%0b drops=%0d expected 0/0", bus.overflow, bus.drop_count); end
        checks++; if ({bus.head_x, bus.head_y, bus.head_color} !== 19'd0) begin errors++; $display("FAIL reset_head: got %0h expected 0", {bus.head_x, bus.head_y, bus.head_color}); end
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_single();
        step(1, 8'd10, 8'd20, 3'b101, 0, 0);
        checks++; if (bus.head_valid !== 1'b1 || bus.level !== 4'd1) begin errors++; $display("FAIL single_push_valid: got valid=%0b level=%0d expected 1/1", bus.head_valid, bus.level); end
        checks++; if (bus.head_x !== 8'd10 || bus.head_y !== 8'd20 || bus.head_color !== 3'd5) begin errors++; $display("FAIL single_push_head: got %0d,%0d,%0d expected 10,20,5", bus.head_x, bus.head_y, bus.head_color); end
        step(0, 0, 0, 0, 1, 0);
        checks++; if (bus.head_valid !== 1'b0 || bus.level !== 4'd0) begin errors++; $display("FAIL single_pop: got valid=%0b level=%0d expected 0/0", bus.head_valid, bus.level); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(i), 8'(i + 1), 3'(i), 0, 0);
            if (i == 4) begin
                checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL afull_at5: got %0b expected 0", bus.almost_full); end
            end
            if (i == 5) begin
                checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL afull_at6: got %0b expected 1", bus.almost_full); end
            end
        end
        checks++; if (bus.level !== 4'd8 || bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_level: got level=%0d ovf=%0b expected 8/0", bus.level, bus.overflow); end
        step(1, 8'd99, 8'd99, 3'd7, 0, 0);
        checks++; if (bus.level !== 4'd8 || bus.almost_full !== 1'b1) begin errors++; $display("FAIL drop_level: got level=%0d af=%0b expected 8/1", bus.level, bus.almost_full); end
        checks++; if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd1) begin errors++; $display("FAIL drop_flags: got ovf=%0b drops=%0d expected 1/1", bus.overflow, bus.drop_count); end
        checks++; if (bus.head_x !== 8'd0) begin errors++; $display("FAIL drop_head_stable: got %0d expected 0", bus.head_x); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.head_x !== 8'(i) || bus.head_y !== 8'(i + 1) || bus.head_color !== 3'(i)) begin errors++; $display("FAIL drain_order[%0d]: got %0d,%0d,%0d expected %0d,%0d,%0d", i, bus.head_x, bus.head_y, bus.head_color, i, i + 1, i % 8); end
            step(0, 0, 0, 0, 1, 0);
        end
        checks++; if (bus.head_valid !== 1'b0 || bus.level !== 4'd0 || bus.overflow !== 1'b1) begin errors++; $display("FAIL drained: got valid=%0b level=%0d ovf=%0b expected 0/0/1", bus.head_valid, bus.level, bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        step(0, 0, 0, 0, 0, 1);
        checks++; if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin errors++; $display("FAIL clear_flags: got ovf=%0b drops=%0d expected 0/0", bus.overflow, bus.drop_count); end
        for (int i = 0; i < 8; i++) step(1, 8'(10 + i), 8'd1, 3'd2, 0, 0);
        step(1, 8'd50, 8'd51, 3'd6, 1, 0);
        checks++; if (bus.level !== 4'd8 || bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin errors++; $display("FAIL full_pushpop: got level=%0d ovf=%0b drops=%0d expected 8/0/0", bus.level, bus.overflow, bus.drop_count); end
        for (int i = 0; i < 8; i++) begin
            automatic logic [7:0] exp_x = (i < 7) ? 8'(11 + i) : 8'd50;
            checks++; if (bus.head_x !== exp_x) begin errors++; $display("FAIL full_pushpop_order[%0d]: got %0d expected %0d", i, bus.head_x, exp_x); end
            step(0, 0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_empty_pop();
        step(0, 0, 0, 0, 1, 0);
        checks++; if (bus.level !== 4'd0 || bus.head_valid !== 1'b0) begin errors++; $display("FAIL empty_pop: got level=%0d valid=%0b expected 0/0", bus.level, bus.head_valid); end
        step(1, 8'd33, 8'd44, 3'd3, 1, 0);
        checks++; if (bus.level !== 4'd1 || bus.head_x !== 8'd33 || bus.head_y !== 8'd44 || bus.head_color !== 3'd3) begin errors++; $display("FAIL empty_pushpop: got level=%0d head=%0d,%0d,%0d expected 1 33,44,3", bus.level, bus.head_x, bus.head_y, bus.head_color); end
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 8; i++) step(1, 8'(i), 8'd0, 3'd0, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 8'd77, 8'd77, 3'd1, 0, 0);
        checks++; if (bus.drop_count !== 8'd255 || bus.overflow !== 1'b1 || bus.level !== 4'd8) begin errors++; $display("FAIL saturate: got drops=%0d ovf=%0b level=%0d expected 255/1/8", bus.drop_count, bus.overflow, bus.level); end
        step(1, 8'd5, 8'd5, 3'd5, 0, 1);
        checks++; if (bus.level !== 4'd0 || bus.overflow !== 1'b0 || bus.drop_count !== 8'd0 || bus.head_valid !== 1'b0) begin errors++; $display("FAIL clear_priority: got level=%0d ovf=%0b drops=%0d valid=%0b expected 0/0/0/0", bus.level, bus.overflow, bus.drop_count, bus.head_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1, 8'(40 + i), 8'd9, 3'd4, 0, 0);
        checks++; if (bus.level !== 4'd5 || bus.head_x !== 8'd40) begin errors++; $display("FAIL pre_reset: got level=%0d head_x=%0d expected 5/40", bus.level, bus.head_x); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.level !== 4'd0 || bus.head_valid !== 1'b0 || bus.almost_full !== 1'b0) begin errors++; $display("FAIL async_reset: got level=%0d valid=%0b af=%0b expected 0/0/0", bus.level, bus.head_valid, bus.almost_full); end
        checks++; if ({bus.head_x, bus.head_y, bus.head_color} !== 19'd0) begin errors++; $display("FAIL async_reset_head: got %0h expected 0", {bus.head_x, bus.head_y, bus.head_color}); end
        #1;
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        checks++; if (bus.head_valid !== 1'b0 || bus.level !== 4'd0) begin errors++; $display("FAIL post_reset_idle: got valid=%0b level=%0d expected 0/0", bus.head_valid, bus.level); end
        step(1, 8'd7, 8'd8, 3'd2, 0, 0);
        checks++; if (bus.head_valid !== 1'b1 || bus.head_x !== 8'd7 || bus.level !== 4'd1) begin errors++; $display("FAIL post_reset_push: got valid=%0b x=%0d level=%0d expected 1/7/1", bus.head_valid, bus.head_x, bus.level); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.clear    = 1'b0;
        bus.x_in     = '0;
        bus.y_in     = '0;
        bus.color_in = '0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_empty_pop();
        test_saturate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_queue.md
PIXEL_QUEUE -- requirements
Module: pixel_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of pixel entries held; SHALL be a power of two, 2..16.
REQ-002 Parameter AFULL_LEVEL, default 6, occupancy at or above which almost_full asserts.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 push  input  1  one-cycle strobe from the packet generator (its valid): enqueue x_in/y_in/color_in.
REQ-006 x_in  input  8  pixel column.
REQ-007 y_in  input  8  pixel row.
REQ-008 color_in  input  3  RGB colour bits {R,G,B}.
REQ-009 pop  input  1  one-cycle strobe from the I2C slave after a complete pixel read: retire head entry.
REQ-010 clear  input  1  synchronous flush of all entries and flags.
REQ-011 head_x / head_y  output  8 each  oldest entry coordinates.
REQ-012 head_color  output  3  oldest entry colour.
REQ-013 head_valid  output  1  queue non-empty; head_* meaningful.
REQ-014 level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 almost_full  output  1  level >= AFULL_LEVEL; back-pressure hint to the packet generator.
REQ-016 overflow  output  1  sticky: a push was dropped.
REQ-017 drop_count  output  8  saturating count of dropped pushes.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH 19-bit words {color,y,x} with write and read pointers of $clog2(DEPTH) bits wrapping modulo DEPTH.
REQ-019 Head outputs SHALL be first-word-fall-through: push into empty queue at edge N gives head_valid=1 and head_* = that entry after edge N (visible in cycle N+1).
REQ-020 head_* SHALL be stable while head_valid=1 and no pop occurs, regardless of pushes.
REQ-021 Push with level<DEPTH SHALL write the entry and increment level by 1.
REQ-022 Push with level==DEPTH and no pop SHALL be dropped: storage unchanged, overflow set, drop_count incremented, saturating at 255.
REQ-023 Pop with level>0 SHALL advance the read pointer and decrement level by 1; the next entry appears on head_* the following cycle.
REQ-024 Pop with level==0 SHALL be ignored with no state change.
REQ-025 Simultaneous push and pop with 0<level<=DEPTH SHALL both take effect, level unchanged; when full this SHALL NOT count as a drop.
REQ-026 Simultaneous push and pop with level==0 SHALL enqueue the push and ignore the pop (level becomes 1).
REQ-027 clear SHALL take priority over push and pop in the same cycle: pointers, level, overflow and drop_count return to 0 on the next edge.
REQ-028 overflow and drop_count SHALL change only through REQ-022 and through clear or reset.
REQ-029 almost_full and head_valid SHALL be derived combinationally from registered level only.

Reset
REQ-030 rst asserted SHALL immediately force pointers=0, level=0, head_valid=0, almost_full=0, overflow=0, drop_count=0; head_x/head_y/head_color SHALL read 0.
REQ-031 Storage contents need not be reset; reset mid-operation SHALL discard all entries with no partial pop or push taking effect.

Structure
REQ-032 Shared package tiny_canvas_pkg SHALL hold COORD_W=8, COLOR_W=3 and the packed pixel-entry type {color,y,x}, shared with the packet generator and I2C slave.
REQ-033 Storage array SHALL be a sub-module pixel_queue_mem (write port, combinational read port, no reset); pointer, level and flag logic SHALL stay in pixel_queue.

Verification
REQ-034 Reset, then push (10,20,3'b101) -> next cycle head_valid=1, head_x=10, head_y=20, head_color=5, level=1; pop -> head_valid=0, level=0.
REQ-035 Push 8 entries x=0..7 then a 9th (x=99) -> level=8, almost_full=1, overflow=1, drop_count=1; 8 pops return x=0..7 in order.
REQ-036 Full queue, push and pop together -> level stays 8, overflow stays 0, the new entry emerges last.
REQ-037 Pop on empty, then push+pop together on empty -> level=1, head is the pushed entry.
REQ-038 300 pushes into a full queue -> drop_count=255; then clear together with push -> level=0, overflow=0, drop_count=0.
REQ-039 Assert rst mid-stream with level=5 between clock edges -> outputs zero immediately; after release head_valid=0 until the next push.
